// File: rtl/syncfifo_pkg.sv
// Shared defaults, FSM state type and lane-mask helper for the synchronous FIFO
// read-side logic.
package syncfifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_RATIO_DEF = 4;
  localparam int MAX_LANES      = 16;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_FLUSH   = 1'b1
  } state_t;

  // Lane-valid mask for a word holding n entries, lane 0 first.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned n);
    logic [MAX_LANES-1:0] mask;
    mask = {MAX_LANES{1'b0}};
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      mask[i] = (i < n);
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_pack_outreg.sv
// Valid/ready output holding register for packed words; contents stay stable
// while the downstream stalls.
module fifo_pack_outreg
  import syncfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_RATIO = PACK_RATIO_DEF
) (
  input  logic                           clock,
  input  logic                           fifo_rst_n,
  input  logic                           load,
  input  logic [DATA_WIDTH*PACK_RATIO-1:0] load_data,
  input  logic [PACK_RATIO-1:0]          load_keep,
  input  logic                           m_ready,
  output logic                           m_valid,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]          m_keep
);

  localparam int WORD_WIDTH = DATA_WIDTH * PACK_RATIO;

  logic                  valid_r;
  logic [WORD_WIDTH-1:0] data_r;
  logic [PACK_RATIO-1:0] keep_r;

  // Output word register: a load wins over an accept on the same edge.
  always_ff @(posedge clock) begin
    if (!fifo_rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {WORD_WIDTH{1'b0}};
      keep_r  <= {PACK_RATIO{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      keep_r  <= load_keep;
    end else if (m_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign m_valid = valid_r;
  assign m_data  = data_r;
  assign m_keep  = keep_r;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a one-cycle-latency FIFO read port and packs PACK_RATIO entries per
// output word; flush emits a partial word. FIFO_RD_PACKER_MSB_FIRST_EN puts the
// first entry in the top lane.
module fifo_rd_packer
  import syncfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK_RATIO = PACK_RATIO_DEF,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                             clock,
  input  logic                             fifo_rst_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_read_data,
  output logic                             fifo_read_enable,
  input  logic                             flush,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             busy
);

  localparam int WORD_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam int LANE_WIDTH = $clog2(PACK_RATIO);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(PACK_RATIO);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  state_t                state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_eff_s, cnt_nxt_s;
  logic [CNT_WIDTH:0]    occupancy_s;
  logic                  inflight_r, busy_r;
  logic [WORD_WIDTH-1:0] pack_r, load_data_s;
  logic [LANE_WIDTH-1:0] lane_sel_s;
  logic [MAX_LANES-1:0]  keep_full_s;
  logic [PACK_RATIO-1:0] keep_lin_s, keep_out_s, load_keep_s;
  logic                  out_free_s, xfer_s, flush_load_s, load_s, rd_en_s;
  logic                  unused_keep_s;

  assign out_free_s  = !m_valid || m_ready;
  assign xfer_s      = (cnt_r == CNT_FULL) && out_free_s;
  assign cnt_eff_s   = xfer_s ? CNT_ZERO : cnt_r;
  assign occupancy_s = {1'b0, cnt_eff_s} + {{CNT_WIDTH{1'b0}}, inflight_r};
  assign load_s      = xfer_s || flush_load_s;
  assign cnt_nxt_s   = load_s ? CNT_ZERO : (cnt_r + {{(CNT_WIDTH-1){1'b0}}, inflight_r});

`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
  assign lane_sel_s = ~cnt_r[LANE_WIDTH-1:0];
`else
  assign lane_sel_s = cnt_r[LANE_WIDTH-1:0];
`endif

  assign keep_full_s   = keep_mask(32'(cnt_r));
  assign keep_lin_s    = keep_full_s[PACK_RATIO-1:0];
  assign unused_keep_s = |keep_full_s[MAX_LANES-1:PACK_RATIO];

  // Keep mask in physical lane order, and the outgoing word with unused lanes zeroed.
  always_comb begin
    keep_out_s  = {PACK_RATIO{1'b0}};
    load_data_s = {WORD_WIDTH{1'b0}};
    for (int i = 0; i < PACK_RATIO; i++) begin
`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
      keep_out_s[PACK_RATIO-1-i] = keep_lin_s[i];
`else
      keep_out_s[i] = keep_lin_s[i];
`endif
    end
    load_keep_s = xfer_s ? {PACK_RATIO{1'b1}} : keep_out_s;
    for (int i = 0; i < PACK_RATIO; i++) begin
      load_data_s[i*DATA_WIDTH +: DATA_WIDTH] =
        load_keep_s[i] ? pack_r[i*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!fifo_rst_n) begin
      state_r <= S_COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a flush parks reads until the pending lanes have drained.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_COLLECT: begin
        if (flush) begin
          state_nxt_s = S_FLUSH;
        end else begin
          state_nxt_s = S_COLLECT;
        end
      end
      S_FLUSH: begin
        if (!inflight_r && ((cnt_r == CNT_ZERO) || out_free_s)) begin
          state_nxt_s = S_COLLECT;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      default: state_nxt_s = S_COLLECT;
    endcase
  end

  // FSM outputs: read request while collecting, partial load once flushing settles.
  always_comb begin
    rd_en_s      = 1'b0;
    flush_load_s = 1'b0;
    case (state_r)
      S_COLLECT: begin
        rd_en_s      = fifo_rst_n && !fifo_empty && (occupancy_s < {1'b0, CNT_FULL});
        flush_load_s = 1'b0;
      end
      S_FLUSH: begin
        rd_en_s      = 1'b0;
        flush_load_s = !inflight_r && (cnt_r != CNT_ZERO) && (cnt_r != CNT_FULL) && out_free_s;
      end
      default: begin
        rd_en_s      = 1'b0;
        flush_load_s = 1'b0;
      end
    endcase
  end

  // Lane counter, read-latency tracking, lane capture and busy flag.
  always_ff @(posedge clock) begin
    if (!fifo_rst_n) begin
      cnt_r      <= CNT_ZERO;
      inflight_r <= 1'b0;
      busy_r     <= 1'b0;
      pack_r     <= {WORD_WIDTH{1'b0}};
    end else begin
      cnt_r      <= cnt_nxt_s;
      inflight_r <= rd_en_s;
      busy_r     <= (cnt_nxt_s != CNT_ZERO) || rd_en_s || (state_nxt_s == S_FLUSH);
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (inflight_r && (lane_sel_s == LANE_WIDTH'(i))) begin
          pack_r[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_read_data;
        end
      end
    end
  end

  assign fifo_read_enable = rd_en_s;
  assign busy             = busy_r;

  fifo_pack_outreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_RATIO (PACK_RATIO)
  ) u_outreg (
    .clock      (clock),
    .fifo_rst_n (fifo_rst_n),
    .load       (load_s),
    .load_data  (load_data_s),
    .load_keep  (load_keep_s),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_keep     (m_keep)
  );

endmodule
